// File: rtl/comparator_4bit.sv
// Registered WIDTH-bit magnitude comparator, unsigned or two's complement,
// with cascade inputs for building wider comparators from several stages.
module comparator_4bit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   input  logic             casc_gt,
   input  logic             casc_lt,
   input  logic             casc_eq,
   output logic             out_valid,
   output logic             AlB,
   output logic             AgB,
   output logic             AeB
);

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] b_ext;
   logic [WIDTH:0] diff;
   logic           ops_eq;
   logic           mag_lt;
   logic           unused_casc_eq;

   logic valid_d, valid_q;
   logic lt_d, lt_q;
   logic gt_d, gt_q;
   logic eq_d, eq_q;

   // One extra bit keeps the difference exact in both modes.
   assign a_ext = {signed_mode & A[WIDTH-1], A};
   assign b_ext = {signed_mode & B[WIDTH-1], B};
   assign diff  = a_ext - b_ext;
   assign mag_lt = diff[WIDTH];
   assign ops_eq = (A == B);

   // Equality is the fall-through case, so casc_eq carries no information.
   assign unused_casc_eq = casc_eq;

   always_comb begin
      valid_d = in_valid;
      lt_d    = lt_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      if (in_valid) begin
         lt_d = 1'b0;
         gt_d = 1'b0;
         eq_d = 1'b0;
         unique case (1'b1)
            !ops_eq && mag_lt:  lt_d = 1'b1;
            !ops_eq && !mag_lt: gt_d = 1'b1;
            ops_eq && casc_gt:  gt_d = 1'b1;
            ops_eq && !casc_gt && casc_lt:
               lt_d = 1'b1;
            default:            eq_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         lt_q    <= lt_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
      end
   end

   assign out_valid = valid_q;
   assign AlB       = lt_q;
   assign AgB       = gt_q;
   assign AeB       = eq_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Randomized and directed checks of comparator_4bit against an
// integer-arithmetic reference model.
module tb_comparator_4bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] A, B;
   logic       signed_mode;
   logic       casc_gt, casc_lt, casc_eq;
   logic       out_valid, AlB, AgB, AeB;

   int total = 0;
   int bad   = 0;

   comparator_4bit #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .A(A), .B(B), .signed_mode(signed_mode),
      .casc_gt(casc_gt), .casc_lt(casc_lt), .casc_eq(casc_eq),
      .out_valid(out_valid), .AlB(AlB), .AgB(AgB), .AeB(AeB)
   );

   always #5 clk = ~clk;

   // Returns {lt,gt,eq} from integer values of the operands.
   function automatic logic [2:0] model(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic sm,
                                        input logic cg,
                                        input logic cl);
      int va, vb;
      va = int'(a);
      vb = int'(b);
      if (sm && va >= 8) va = va - 16;
      if (sm && vb >= 8) vb = vb - 16;
      if (va < vb) return 3'b100;
      if (va > vb) return 3'b010;
      if (cg) return 3'b010;
      if (cl) return 3'b100;
      return 3'b001;
   endfunction

   task automatic drive(input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic sm,
                        input logic cg, input logic cl, input logic ce);
      in_valid = v; A = a; B = b; signed_mode = sm;
      casc_gt = cg; casc_lt = cl; casc_eq = ce;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 4'b0010, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({out_valid, AlB, AgB, AeB} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold[%0d] got %b want 0000", i,
                     {out_valid, AlB, AgB, AeB});
         end
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle got out_valid=%b want 0", out_valid);
      end
      in_valid = 1'b1;
      tick();
      total++;
      if ({out_valid, AlB, AgB, AeB} !== 4'b1100) begin
         bad++;
         $display("FAIL reset_first got %b want 1100",
                  {out_valid, AlB, AgB, AeB});
      end
   endtask

   task automatic test_unsigned();
      logic [3:0] av[5] = '{4'b0010, 4'b1010, 4'b0010, 4'b1110, 4'b0011};
      logic [3:0] bv[5] = '{4'b1001, 4'b1001, 4'b0010, 4'b1000, 4'b1001};
      logic [2:0] ex[5] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, av[i], bv[i], 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
         total++;
         if (out_valid !== 1'b1 || {AlB, AgB, AeB} !== ex[i]) begin
            bad++;
            $display("FAIL unsigned[%0d] got v=%b f=%b want v=1 f=%b",
                     i, out_valid, {AlB, AgB, AeB}, ex[i]);
         end
      end
   endtask

   task automatic test_signed();
      logic [3:0] av[5] = '{4'b0010, 4'b1010, 4'b0011, 4'b1000, 4'b1111};
      logic [3:0] bv[5] = '{4'b1001, 4'b1001, 4'b1001, 4'b0111, 4'b1111};
      logic [2:0] ex[5] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, av[i], bv[i], 1'b1, 1'b0, 1'b0, 1'b1);
         tick();
         total++;
         if (out_valid !== 1'b1 || {AlB, AgB, AeB} !== ex[i]) begin
            bad++;
            $display("FAIL signed[%0d] got v=%b f=%b want v=1 f=%b",
                     i, out_valid, {AlB, AgB, AeB}, ex[i]);
         end
      end
   endtask

   task automatic test_cascade();
      logic [3:0] av[5] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0110};
      logic [2:0] cv[5] = '{3'b100, 3'b010, 3'b110, 3'b000, 3'b010};
      logic [2:0] ex[5] = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b010};
      logic [2:0] c;
      for (int i = 0; i < 5; i++) begin
         c = cv[i];
         drive(1'b1, av[i], 4'b0101, 1'b0, c[2], c[1], c[0]);
         tick();
         total++;
         if (out_valid !== 1'b1 || {AlB, AgB, AeB} !== ex[i]) begin
            bad++;
            $display("FAIL cascade[%0d] got v=%b f=%b want v=1 f=%b",
                     i, out_valid, {AlB, AgB, AeB}, ex[i]);
         end
      end
   endtask

   task automatic test_valid_gating();
      drive(1'b1, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      total++;
      if ({out_valid, AlB, AgB, AeB} !== 4'b1010) begin
         bad++;
         $display("FAIL gate_first got %b want 1010",
                  {out_valid, AlB, AgB, AeB});
      end
      drive(1'b0, 4'd1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      total++;
      if ({out_valid, AlB, AgB, AeB} !== 4'b0010) begin
         bad++;
         $display("FAIL gate_hold got %b want 0010",
                  {out_valid, AlB, AgB, AeB});
      end
      in_valid = 1'b1;
      tick();
      total++;
      if ({out_valid, AlB, AgB, AeB} !== 4'b1100) begin
         bad++;
         $display("FAIL gate_resume got %b want 1100",
                  {out_valid, AlB, AgB, AeB});
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      total++;
      if ({out_valid, AlB, AgB, AeB} !== 4'b1001) begin
         bad++;
         $display("FAIL midrst_pre got %b want 1001",
                  {out_valid, AlB, AgB, AeB});
      end
      rst_n = 1'b0;
      tick();
      total++;
      if ({out_valid, AlB, AgB, AeB} !== 4'b0000) begin
         bad++;
         $display("FAIL midrst_clear got %b want 0000",
                  {out_valid, AlB, AgB, AeB});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      logic [2:0] ex;
      logic [2:0] got;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 256; i++) begin
            drive(1'b1, i[7:4], i[3:0], m[0], 1'b0, 1'b0, 1'b1);
            ex = model(i[7:4], i[3:0], m[0], 1'b0, 1'b0);
            tick();
            got = {AlB, AgB, AeB};
            total++;
            if (out_valid !== 1'b1 || got !== ex || !$onehot(got)) begin
               bad++;
               $display("FAIL sweep m=%0d a=%b b=%b got v=%b f=%b want f=%b",
                        m, i[7:4], i[3:0], out_valid, got, ex);
            end
         end
      end
   endtask

   task automatic test_back_to_back_random();
      logic [2:0] held;
      logic [2:0] got;
      logic       v, sm, cg, cl;
      logic [3:0] a, b;
      held = {AlB, AgB, AeB};
      for (int i = 0; i < 300; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         a  = 4'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? a : 4'($urandom);
         sm = 1'($urandom);
         cg = 1'($urandom);
         cl = 1'($urandom);
         drive(v, a, b, sm, cg, cl, 1'($urandom));
         if (v) held = model(a, b, sm, cg, cl);
         tick();
         got = {AlB, AgB, AeB};
         total++;
         if (out_valid !== v || got !== held) begin
            bad++;
            $display("FAIL random[%0d] got v=%b f=%b want v=%b f=%b",
                     i, out_valid, got, v, held);
         end
      end
   endtask

   initial begin
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      test_reset();
      test_unsigned();
      test_signed();
      test_cascade();
      test_valid_gating();
      test_mid_reset();
      test_sweep();
      test_back_to_back_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/comparator_4bit.md
Name: comparator_4bit

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 4).
- Produces one-hot less/greater/equal flags one cycle after a valid input.
- Supports unsigned or two's-complement compare, selectable per transaction.
- Has 7485-style cascade inputs, so several instances can be chained into wider comparators. Used as a leaf compare stage in datapath control.

Parameters:
- WIDTH, 4, operand width in bits (≥1); all compare logic scales with it.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  A, B, signed_mode and cascade inputs are sampled this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare.
- casc_gt  input  1  cascade "greater" from the less-significant stage; tie 0 when standalone.
- casc_lt  input  1  cascade "less" from the less-significant stage; tie 0 when standalone.
- casc_eq  input  1  cascade "equal" from the less-significant stage; tie 1 when standalone.
- out_valid  output  1  the flags below hold a new result.
- AlB  output  1  A < B.
- AgB  output  1  A > B.
- AeB  output  1  A == B (including cascade).

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low (rst_n sampled low at a rising edge of clk).
  - On reset, out_valid, AlB, AgB and AeB all go to 0.
  - Reset takes priority over in_valid in the same cycle; any in-flight result is discarded.
- Latency: exactly 1 cycle. Inputs sampled at edge N while in_valid=1 give the result and out_valid=1 after edge N.
- out_valid equals in_valid registered; no backpressure. A new input can be accepted every cycle.
- When in_valid=0, out_valid drops to 0 at the next edge. AlB/AgB/AeB hold their last values and are ignored by consumers.
- Compare rules:
  - signed_mode=0: A and B are unsigned, range 0..2^WIDTH−1.
  - signed_mode=1: A and B are two's complement; the MSB is the sign (1010 = −6 for WIDTH=4).
  - A and B differ: AgB/AlB come from the magnitude result only. Cascade inputs are ignored.
  - A == B (bitwise): the result is taken from the cascade inputs, priority casc_gt, then casc_lt, else equal.
    - casc_gt=1 gives AgB.
    - Otherwise casc_lt=1 gives AlB.
    - Otherwise AeB, including the all-zero cascade input combination.
- Whenever out_valid=1, exactly one of AlB/AgB/AeB is 1; the flags are one-hot.
- Chaining: an upper stage's casc_* inputs connect to the lower stage's AgB/AlB/AeB. The user aligns pipeline timing. Only the most significant stage uses signed_mode=1.
- Boundaries:
  - All-zeros vs all-ones: unsigned gives AlB; signed (0 vs −1) gives AgB.
  - Min-negative vs max-positive in signed mode (1000 vs 0111) gives AlB.
- No internal overflow. The compare must not use a subtractor narrower than WIDTH+1 bits.

Test Plan:
- Unsigned standalone (signed_mode=0, casc_eq=1, casc_gt=casc_lt=0), one vector per cycle:
  - 0010 vs 1001 gives AlB=1.
  - 1010 vs 1001 gives AgB=1.
  - 0010 vs 0010 gives AeB=1.
  - 1110 vs 1000 gives AgB=1.
  - 0011 vs 1001 gives AlB=1.
  - Each result appears with out_valid=1 one cycle after input, back-to-back.
- Signed mode:
  - 0010 vs 1001 (2 vs −7) gives AgB.
  - 1010 vs 1001 (−6 vs −7) gives AgB.
  - 0011 vs 1001 gives AgB.
  - 1000 vs 0111 gives AlB.
  - 1111 vs 1111 gives AeB.
- Cascade with A=B=0101:
  - casc_gt=1 gives AgB.
  - casc_lt=1 (casc_gt=0) gives AlB.
  - casc_gt=casc_lt=1 gives AgB.
  - All cascade inputs 0 gives AeB.
  - A=0110, B=0101 with casc_lt=1 gives AgB.
- Reset:
  - Hold rst_n=0 for 2 cycles with in_valid=1: all outputs stay 0.
  - Deassert rst_n: the first result appears one cycle after the first sampled valid input.
  - Asserting rst_n=0 mid-stream clears out_valid and all flags at the next edge.
- Valid gating:
  - in_valid pattern 1,0,1 gives out_valid 1,0,1 delayed by 1 cycle.
  - Flags hold during the gap.
- Exhaustive sweep: all 256 A/B pairs in both modes; check flags are one-hot and match a reference model.
